// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
// The fetch stage issues requests; memory returns responses in request order.
`timescale 1ns/1ps
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: credit-limited requests, a 2-entry {pc, instruction} buffer,
// and discard of stale responses after a branch/jump redirect.
`timescale 1ns/1ps
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nop_lock_id,
  input  logic        pc_bj,
  input  logic [31:0] bj_target,
  if_fetch_if.master  imem,
  output logic [31:0] instruction_if,
  output logic [31:0] pc_if,
  output logic        valid_if
);

  logic [31:0] r_fetch_pc;
  logic [1:0]  r_outstanding;
  logic [1:0]  r_drop;
  logic [1:0]  r_count;
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [31:0] r_pc_last;
  logic [31:0] r_fifo_pc  [2];
  logic [31:0] r_fifo_ins [2];

  logic [2:0]  w_used;
  logic        w_credit;
  logic        w_accept;
  logic        w_rsp;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_rsp_pc;

  // Both in-flight requests and buffered words hold a credit.
  assign w_used   = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_credit = (w_used < 3'd2);

  assign imem.imem_req  = ~rst & w_credit & ~pc_bj;
  assign imem.imem_addr = r_fetch_pc;

  assign w_accept = imem.imem_req & imem.imem_ready;
  // A response with nothing in flight is a protocol error and is ignored.
  assign w_rsp    = imem.imem_rvalid & (r_outstanding != 2'd0);
  assign w_push   = w_rsp & (r_drop == 2'd0) & ~pc_bj;

  assign valid_if = (r_count != 2'd0);
  assign w_pop    = valid_if & ~nop_lock_id & ~pc_bj;

  // Once drop is 0 every in-flight request is live and they are the consecutive
  // words just below fetch_pc, so the oldest one sits outstanding*4 bytes back.
  assign w_rsp_pc = r_fetch_pc - {28'd0, r_outstanding, 2'b00};

  assign instruction_if = valid_if ? r_fifo_ins[r_rd_ptr] : 32'h0000_0000;
  assign pc_if          = valid_if ? r_fifo_pc[r_rd_ptr]  : r_pc_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= 2'd0;
      r_drop        <= 2'd0;
      r_count       <= 2'd0;
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_pc_last     <= 32'h0000_0000;
    end else begin
      if (valid_if) r_pc_last <= r_fifo_pc[r_rd_ptr];

      case ({w_accept, w_rsp})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   r_outstanding <= r_outstanding - 2'd1;
        default: ;
      endcase

      if (pc_bj) begin
        // Everything still in flight after this edge is stale.
        r_fetch_pc <= bj_target;
        r_drop     <= r_outstanding - {1'b0, w_rsp};
        r_count    <= 2'd0;
        r_rd_ptr   <= 1'b0;
        r_wr_ptr   <= 1'b0;
      end else begin
        if (w_accept)                   r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_rsp && (r_drop != 2'd0))  r_drop     <= r_drop - 2'd1;
        if (w_push)                     r_wr_ptr   <= ~r_wr_ptr;
        if (w_pop)                      r_rd_ptr   <= ~r_rd_ptr;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: buffer storage is not reset; r_count alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]  <= w_rsp_pc;
      r_fifo_ins[r_wr_ptr] <= imem.imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle table, directed stall/redirect/reset sequences,
// and a randomized run against a program-order reference model.
`timescale 1ns/1ps
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        nop_lock_id;
  logic        pc_bj;
  logic [31:0] bj_target;
  logic [31:0] instruction_if;
  logic [31:0] pc_if;
  logic        valid_if;
  logic [31:0] w_instruction_if;
  logic [31:0] w_pc_if;
  logic        w_valid_if;

  int checks = 0;
  int errors = 0;

  if_fetch_if bus ();
  if_fetch_if bus_w ();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .nop_lock_id(nop_lock_id), .pc_bj(pc_bj),
    .bj_target(bj_target), .imem(bus), .instruction_if(instruction_if),
    .pc_if(pc_if), .valid_if(valid_if)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .nop_lock_id(1'b0), .pc_bj(1'b0),
    .bj_target(32'h0000_0000), .imem(bus_w), .instruction_if(w_instruction_if),
    .pc_if(w_pc_if), .valid_if(w_valid_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Memory model for the main DUT: in-order queue of accepted addresses.
  logic [31:0] mq[$];
  bit mode_rand = 1'b0;
  bit hold_rsp  = 1'b0;
  bit spurious  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) mq.delete();
    else begin
      if (bus.imem_rvalid && mq.size() > 0) void'(mq.pop_front());
      if (bus.imem_req && bus.imem_ready) mq.push_back(bus.imem_addr);
    end
  end

  always @(negedge clk) begin
    bus.imem_ready = mode_rand ? ($urandom_range(3) != 0) : 1'b1;
    if (spurious) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end else if (mq.size() > 0 && !hold_rsp && (!mode_rand || $urandom_range(1) == 1)) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(mq[0]);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
  end

  // Memory model for the wrap-around DUT: always ready, one-cycle latency.
  logic [31:0] mqw[$];
  always @(posedge clk or posedge rst) begin
    if (rst) mqw.delete();
    else begin
      if (bus_w.imem_rvalid && mqw.size() > 0) void'(mqw.pop_front());
      if (bus_w.imem_req && bus_w.imem_ready) mqw.push_back(bus_w.imem_addr);
    end
  end

  always @(negedge clk) begin
    bus_w.imem_ready  = 1'b1;
    bus_w.imem_rvalid = (mqw.size() > 0);
    bus_w.imem_rdata  = (mqw.size() > 0) ? mem_word(mqw[0]) : 32'h0000_0000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Returns at a falling edge with rst released; the DUT's first edge is next.
  task automatic do_reset(input bit rand_mode);
    rst = 1'b1;
    nop_lock_id = 1'b0;
    pc_bj = 1'b0;
    bj_target = 32'h0;
    mode_rand = rand_mode;
    hold_rsp = 1'b0;
    spurious = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a falling edge; runs unstalled until the next word is consumed.
  task automatic expect_pop(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      nop_lock_id = 1'b0;
      pc_bj = 1'b0;
      #1;
      if (valid_if) begin
        check(name, pc_if, exp_pc);
        check({name, "_ins"}, instruction_if, mem_word(exp_pc));
        seen = 1'b1;
      end
      @(negedge clk);
    end
    if (!seen) fail_timeout(name);
  endtask

  // Returns 1ns after a falling edge where the head holds pc.
  task automatic wait_head(input string name, input logic [31:0] pc);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      #1;
      if (valid_if && pc_if == pc) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) fail_timeout(name);
  endtask

  typedef struct {
    logic        nop;
    logic        bj;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_fetch, exp_pop, tgt;
    int pops;
    bit found;
    bit last_bj;

    // Cycle-by-cycle expectations from reset release with an always-ready,
    // one-cycle-latency memory; row 8 redirects to 0x100.
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0, 32'h4};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b0, 32'hC};
    vecs[8]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h10};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h10};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h10};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104};

    rst = 1'b1;
    nop_lock_id = 1'b0;
    pc_bj = 1'b0;
    bj_target = 32'h0;
    #3;
    check("rst_valid", valid_if, 1'b0);
    check("rst_ins", instruction_if, 32'h0);
    check("rst_pc", pc_if, 32'h0);
    check("rst_req", bus.imem_req, 1'b0);

    // Table: main DUT, plus the wrap DUT which tracks it offset by -4 until the redirect.
    do_reset(1'b0);
    for (int i = 0; i < 13; i++) begin
      nop_lock_id = vecs[i].nop;
      pc_bj = vecs[i].bj;
      bj_target = vecs[i].tgt;
      #1;
      check($sformatf("row%0d_req", i), bus.imem_req, vecs[i].e_req);
      if (vecs[i].e_req) check($sformatf("row%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      check($sformatf("row%0d_valid", i), valid_if, vecs[i].e_valid);
      check($sformatf("row%0d_pc", i), pc_if, vecs[i].e_pc);
      check($sformatf("row%0d_ins", i), instruction_if,
            vecs[i].e_valid ? mem_word(vecs[i].e_pc) : 32'h0);
      if (i < 8) begin
        check($sformatf("wrap%0d_valid", i), w_valid_if, vecs[i].e_valid);
        if (vecs[i].e_valid) begin
          check($sformatf("wrap%0d_pc", i), w_pc_if, vecs[i].e_pc - 32'd4);
          check($sformatf("wrap%0d_ins", i), w_instruction_if, mem_word(vecs[i].e_pc - 32'd4));
        end
        if (vecs[i].e_req) check($sformatf("wrap%0d_addr", i), bus_w.imem_addr, vecs[i].e_addr - 32'd4);
      end
      @(negedge clk);
    end

    // Stall at pc 8 for 5 cycles, inject a stray response, then resume.
    do_reset(1'b0);
    wait_head("stall_reach8", 32'h8);
    nop_lock_id = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", valid_if, 1'b1);
      check("stall_pc", pc_if, 32'h8);
      check("stall_ins", instruction_if, mem_word(32'h8));
      @(negedge clk);
      #1;
    end
    check("stall_req_off", bus.imem_req, 1'b0);
    check("stall_inflight", mq.size(), 32'd0);
    spurious = 1'b1;
    @(negedge clk);
    #1;
    spurious = 1'b0;
    check("stray_pc", pc_if, 32'h8);
    @(negedge clk);
    #1;
    check("stray_req_off", bus.imem_req, 1'b0);
    check("stray_pc_after", pc_if, 32'h8);
    @(negedge clk);
    expect_pop("resume8", 32'h8);
    expect_pop("resume12", 32'hC);
    expect_pop("resume16", 32'h10);

    // Redirect with two requests in flight: both stale responses are dropped.
    do_reset(1'b0);
    hold_rsp = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("redir_inflight", mq.size(), 32'd2);
    check("redir_req_off", bus.imem_req, 1'b0);
    pc_bj = 1'b1;
    bj_target = 32'h100;
    hold_rsp = 1'b0;
    #1;
    check("redir_bj_req", bus.imem_req, 1'b0);
    @(negedge clk);
    pc_bj = 1'b0;
    expect_pop("redir_first", 32'h100);
    expect_pop("redir_second", 32'h104);

    // Redirect, response and stall all in the same cycle.
    do_reset(1'b0);
    nop_lock_id = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      #1;
      if (valid_if && bus.imem_rvalid) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) fail_timeout("simul_setup");
    pc_bj = 1'b1;
    bj_target = 32'h200;
    #1;
    check("simul_req", bus.imem_req, 1'b0);
    @(negedge clk);
    pc_bj = 1'b0;
    expect_pop("simul_first", 32'h200);
    expect_pop("simul_second", 32'h204);

    // Asynchronous reset with a request in flight.
    do_reset(1'b0);
    wait_head("rmid_reach8", 32'h8);
    #2;
    rst = 1'b1;
    #1;
    check("rmid_valid", valid_if, 1'b0);
    check("rmid_pc", pc_if, 32'h0);
    check("rmid_ins", instruction_if, 32'h0);
    check("rmid_req", bus.imem_req, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rmid_first_req", bus.imem_req, 1'b1);
    check("rmid_first_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    expect_pop("rmid_pop0", 32'h0);
    expect_pop("rmid_pop4", 32'h4);

    // Randomized run: consumed words follow program order from the last redirect,
    // and requests walk the same address stream.
    do_reset(1'b1);
    exp_fetch = 32'h0;
    exp_pop = 32'h0;
    pops = 0;
    last_bj = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nop_lock_id = ($urandom_range(2) == 0);
      pc_bj = !last_bj && ($urandom_range(15) == 0);
      tgt = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      bj_target = tgt;
      last_bj = pc_bj;
      #1;
      if (!valid_if) check("rand_nop_ins", instruction_if, 32'h0);
      if (bus.imem_req) begin
        check("rand_addr", bus.imem_addr, exp_fetch);
        if (bus.imem_ready) exp_fetch = exp_fetch + 32'd4;
      end
      if (mq.size() > 2) begin
        checks++;
        errors++;
        $display("FAIL rand_credit: %0d requests in flight, limit 2", mq.size());
      end
      if (pc_bj) begin
        check("rand_bj_req", bus.imem_req, 1'b0);
        exp_fetch = tgt;
        exp_pop = tgt;
      end else if (valid_if && !nop_lock_id) begin
        check("rand_pc", pc_if, exp_pop);
        check("rand_ins", instruction_if, mem_word(exp_pop));
        exp_pop = exp_pop + 32'd4;
        pops++;
      end
      @(negedge clk);
    end
    checks++;
    if (pops < 200) begin
      errors++;
      $display("FAIL rand_progress: %0d words consumed, need at least 200", pops);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
